// File: rtl/hazard_sequencer.sv
// Load-use stall, multi-cycle mul/div sequencing and taken-branch flush control for the 5-stage core.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rt_i,
  input  logic       id_md_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic       mem_br_taken_i,
  output logic       pc_write_o,
  output logic       if_id_write_o,
  output logic       if_id_flush_o,
  output logic       id_ex_flush_o,
  output logic       ex_mem_flush_o,
  output logic       md_start_o,
  output logic       md_abort_o,
  output logic       md_busy_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  // state   | meaning
  // RUN     | normal issue; load-use stall and mul/div issue decided here
  // MD_WAIT | mul/div occupies EX; front end held, EX/MEM fed bubbles

  typedef enum logic {RUN, MD_WAIT} state_t;

  if (MD_LAT < 2 || MD_LAT > 15 || CNT_W < 1) begin : g_param_check
    $error("hazard_sequencer: MD_LAT must be 2..15 and CNT_W at least 1");
  end

  state_t     state, state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;
  logic       lu;

  assign lu = idex_memread_i && (idex_rt_i != 5'd0) &&
              ((idex_rt_i == id_rs_i) || (id_use_rt_i && (idex_rt_i == id_rt_i)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Outputs are forced low while reset is asserted, so a reset mid-MD_WAIT never pulses md_abort_o.
  always_comb begin
    state_nxt      = state;
    md_cnt_nxt     = md_cnt;
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    md_start_o     = 1'b0;
    md_abort_o     = 1'b0;
    md_busy_o      = 1'b0;
    if (rst_i) begin
      case (state)
        RUN: begin
          pc_write_o    = 1'b1;
          if_id_write_o = 1'b1;
          if (mem_br_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
          end else if (lu) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
          end else if (id_md_i) begin
            md_start_o = 1'b1;
            state_nxt  = MD_WAIT;
            md_cnt_nxt = 4'(MD_LAT - 1);
          end
        end
        MD_WAIT: begin
          md_busy_o = 1'b1;
          if (mem_br_taken_i) begin
            md_abort_o     = 1'b1;
            pc_write_o     = 1'b1;
            if_id_write_o  = 1'b1;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            state_nxt      = RUN;
            md_cnt_nxt     = 4'd0;
          end else begin
            // Last occupancy cycle lets the result into EX/MEM.
            ex_mem_flush_o = (md_cnt != 4'd1);
            md_cnt_nxt     = md_cnt - 4'd1;
            if (md_cnt == 4'd1) state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt_o != {CNT_W{1'b1}})) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (mem_br_taken_i && (flush_cnt_o != {CNT_W{1'b1}})) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule
